// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its
// downstream display consumers.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCD_W        = 4;
  localparam logic [3:0] ADD3_THRESH  = 4'd5;
  localparam logic [7:0] ASCII_OFFSET = 8'h30;

  // Downstream turns each result nibble into a printable character.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_OFFSET + {4'h0, digit};
  endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// One double-dabble correction stage: adds 3 to a BCD nibble of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one bit per clock, result and
// saturation flag presented with a one-cycle valid pulse BIN_WIDTH+1 cycles after a request.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) (
  input  logic                   internal_clk,
  input  logic                   rst,
  input  logic [BIN_WIDTH-1:0]   data_in,
  input  logic                   data_in_trcvd,
  output logic [4*DIGITS-1:0]    data_out,
  output logic                   data_out_rcvd,
  output logic                   busy,
  output logic                   overflow
);

  localparam int SD    = BIN_WIDTH / 3 + 1;
  localparam int SW    = SD * BCD_W;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  state_e                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [SW-1:0]          scr_q, scr_d;
  logic [SW-1:0]          scr_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    dout_q, dout_d;
  logic                   ovf_q, ovf_d;
  logic [SW+BIN_WIDTH:0]  shifted;
  logic                   hi_nz;

  for (genvar g = 0; g < SD; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[g*BCD_W +: BCD_W]),
      .digit_o (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  // Top bit is whatever falls off the scratch; it counts toward saturation.
  assign shifted = {scr_adj, bin_q, 1'b0};
  assign hi_nz   = |shifted[SW+BIN_WIDTH : BIN_WIDTH+4*DIGITS];

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (data_in_trcvd) begin
          bin_d   = data_in;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = shifted[BIN_WIDTH-1:0];
        scr_d = shifted[SW+BIN_WIDTH-1:BIN_WIDTH];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = DONE;
          ovf_d   = hi_nz;
          dout_d  = hi_nz ? {DIGITS{4'h9}}
                          : shifted[BIN_WIDTH+4*DIGITS-1:BIN_WIDTH];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out      = dout_q;
  assign overflow      = ovf_q;
  assign data_out_rcvd = (state_q == DONE);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: expected results queued at request time,
// checked whenever the converter pulses data_out_rcvd.
module tb_bin_to_bcd;

  logic        internal_clk;
  logic        rst;
  logic [15:0] data_in;
  logic        data_in_trcvd;
  logic [15:0] data_out;
  logic        data_out_rcvd;
  logic        busy;
  logic        overflow;

  int checks;
  int fails;
  int rcvd_cnt;
  logic [15:0] exp_dat_q[$];
  logic        exp_ovf_q[$];

  bin_to_bcd #(.BIN_WIDTH(16), .DIGITS(4)) dut (
    .internal_clk  (internal_clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_trcvd (data_in_trcvd),
    .data_out      (data_out),
    .data_out_rcvd (data_out_rcvd),
    .busy          (busy),
    .overflow      (overflow)
  );

  initial internal_clk = 1'b0;
  always #5 internal_clk = ~internal_clk;

  // Decimal reference, deliberately not a shift-and-add model.
  function automatic void model(input logic [15:0] v, output logic [15:0] d, output logic o);
    if (v > 16'd9999) begin
      d = 16'h9999;
      o = 1'b1;
    end else begin
      d = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      o = 1'b0;
    end
  endfunction

  always @(negedge internal_clk) begin
    if (!rst && data_out_rcvd) begin
      logic [15:0] ed;
      logic        eo;
      rcvd_cnt++;
      checks++;
      if (exp_dat_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rcvd: got data_out=%h overflow=%b, no result was pending", data_out, overflow);
      end else begin
        ed = exp_dat_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (data_out !== ed || overflow !== eo) begin
          fails++;
          $display("FAIL result: got data_out=%h overflow=%b, expected data_out=%h overflow=%b",
                   data_out, overflow, ed, eo);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] v);
    logic [15:0] d;
    logic        o;
    model(v, d, o);
    exp_dat_q.push_back(d);
    exp_ovf_q.push_back(o);
  endtask

  task automatic run_conv(input logic [15:0] v, input bit chg, input logic [15:0] v2);
    int cyc;
    bit seen;
    @(negedge internal_clk);
    data_in       = v;
    data_in_trcvd = 1'b1;
    push_exp(v);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge internal_clk);
      cyc++;
      if (cyc == 1) begin
        data_in_trcvd = 1'b0;
        if (chg) data_in = v2;
        checks++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_after_accept: got %b, expected 1", busy);
        end
      end
      if (data_out_rcvd === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cyc != 17) begin
      fails++;
      $display("FAIL latency(%0d): got %0d cycles (seen=%0d), expected 17", v, cyc, seen);
    end
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    data_in       = 16'h0;
    data_in_trcvd = 1'b1;
    repeat (3) @(negedge internal_clk);
    checks++;
    if (data_out !== 16'h0 || data_out_rcvd !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got data_out=%h rcvd=%b busy=%b ovf=%b, expected all 0",
               data_out, data_out_rcvd, busy, overflow);
    end
    data_in_trcvd = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic test_basic;
    run_conv(16'd1234, 0, 16'd0);
    run_conv(16'd0, 0, 16'd0);
    run_conv(16'd9999, 0, 16'd0);
    run_conv(16'd10000, 0, 16'd0);
    run_conv(16'd65535, 0, 16'd0);
  endtask

  task automatic test_hold;
    logic [15:0] d0;
    logic        o0;
    model(16'd65535, d0, o0);
    repeat (5) @(negedge internal_clk);
    checks++;
    if (data_out !== d0 || overflow !== o0 || busy !== 1'b0 || data_out_rcvd !== 1'b0) begin
      fails++;
      $display("FAIL hold: got data_out=%h ovf=%b busy=%b rcvd=%b, expected %h %b 0 0",
               data_out, overflow, busy, data_out_rcvd, d0, o0);
    end
  endtask

  task automatic test_ignore_busy;
    int start;
    bit busy_ok;
    @(negedge internal_clk);
    data_in       = 16'd500;
    data_in_trcvd = 1'b1;
    push_exp(16'd500);
    start   = rcvd_cnt;
    busy_ok = 1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge internal_clk);
      if (cyc == 1) data_in_trcvd = 1'b0;
      if (cyc == 5) begin
        data_in       = 16'd77;
        data_in_trcvd = 1'b1;
      end
      if (cyc == 6) data_in_trcvd = 1'b0;
      if (cyc <= 17 && busy !== 1'b1) busy_ok = 0;
    end
    checks++;
    if (!busy_ok) begin
      fails++;
      $display("FAIL ignore_busy: busy dropped during conversion, expected 1 throughout");
    end
    checks++;
    if (rcvd_cnt - start != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_pulses: got %0d pulses busy=%b, expected 1 pulse busy=0", rcvd_cnt - start, busy);
    end
    run_conv(16'd77, 0, 16'd0);
  endtask

  task automatic test_reset_abort;
    int start;
    @(negedge internal_clk);
    data_in       = 16'd1234;
    data_in_trcvd = 1'b1;
    start         = rcvd_cnt;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge internal_clk);
      if (cyc == 1) data_in_trcvd = 1'b0;
    end
    rst = 1'b1;
    @(negedge internal_clk);
    checks++;
    if (data_out !== 16'h0 || data_out_rcvd !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL abort_outputs: got data_out=%h rcvd=%b busy=%b ovf=%b, expected all 0",
               data_out, data_out_rcvd, busy, overflow);
    end
    rst = 1'b0;
    repeat (20) @(negedge internal_clk);
    checks++;
    if (rcvd_cnt != start) begin
      fails++;
      $display("FAIL abort_pulse: got %0d pulses, expected 0", rcvd_cnt - start);
    end
    run_conv(16'd42, 0, 16'd0);
  endtask

  task automatic test_data_change;
    run_conv(16'd123, 1, 16'd999);
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom_range(0, 65535));
      run_conv(v, 0, 16'd0);
    end
    run_conv(16'd9998, 0, 16'd0);
    run_conv(16'd10001, 0, 16'd0);
    run_conv(16'd7, 0, 16'd0);
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rcvd_cnt = 0;
    test_reset;
    test_basic;
    test_hold;
    test_ignore_busy;
    test_reset_abort;
    test_data_change;
    test_back_to_back;
    repeat (3) @(negedge internal_clk);
    checks++;
    if (exp_dat_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, expected 0", exp_dat_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
